// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator hall-call front end and controller.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 8;
  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned NUM_SLOTS  = 2 * NUM_FLOORS;
  localparam int unsigned SLOT_W     = FLOOR_W + 1;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    NONE,
    PENDING,
    QUEUED
  } slot_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } issue_state_e;

  // Request payload; its bit pattern equals the slot index {dir, floor}.
  typedef struct packed {
    logic               dir;
    logic [FLOOR_W-1:0] floor;
  } req_t;

  function automatic req_t req_of(logic [SLOT_W-1:0] slot);
    return req_t'(slot);
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(req_t req);
    return {req.dir, req.floor};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debouncer for one hall button.
// Emits a one-cycle pulse when the accepted level rises.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync2_q != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_q <= sync2_q;
          rise_q   <= sync2_q;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/elevator_request_scanner.sv
// Hall-call front end: debounces 16 buttons, latches calls per slot, arbitrates
// round-robin into a FIFO and drains it as gapped single-cycle request strobes.
module elevator_request_scanner
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned GAP_CYCLES      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_FLOORS-1:0] btn_up_i,
  input  logic [NUM_FLOORS-1:0] btn_down_i,
  output logic                  req_valid_o,
  output logic [FLOOR_W-1:0]    req_floor_o,
  output logic                  req_direction_o,
  output logic [NUM_FLOORS-1:0] pending_up_o,
  output logic [NUM_FLOORS-1:0] pending_down_o,
  output logic                  queue_full_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SLOT_W-1:0] SLOT_DOWN0  = {DIR_DOWN, FLOOR_W'(0)};
  localparam logic [SLOT_W-1:0] SLOT_UP_TOP = {DIR_UP, FLOOR_W'(NUM_FLOORS - 1)};

  logic [NUM_SLOTS-1:0] raw;
  logic [NUM_SLOTS-1:0] rise;
  logic [NUM_SLOTS-1:0] rise_ok;

  slot_state_e          slot_q [NUM_SLOTS];
  slot_state_e          slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] pending_q;
  logic [SLOT_W-1:0]    rr_q;

  req_t                 fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic                 full_q;

  issue_state_e         state_q;
  logic [GAP_W-1:0]     gap_q;
  logic                 req_valid_q;
  req_t                 out_q;

  logic                 grant_vld;
  logic [SLOT_W-1:0]    grant_idx;
  logic [SLOT_W-1:0]    scan_idx;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 fsm_ready;

  assign raw = {btn_up_i, btn_down_i};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .raw_i (raw[g]),
      .rise_o(rise[g])
    );
  end

  // Top-floor up and ground-floor down buttons have no meaning.
  always_comb begin
    rise_ok = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      rise_ok[i] = rise[i] && (SLOT_W'(i) != SLOT_DOWN0) && (SLOT_W'(i) != SLOT_UP_TOP);
    end
  end

  // Round-robin search for the first pending slot at or after rr_q.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      scan_idx = rr_q + SLOT_W'(k);
      if (!grant_vld && slot_q[scan_idx] == PENDING) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push      = grant_vld && !fifo_full;

  // The issuer may take a new entry directly at the end of ISSUE/GAP.
  always_comb begin
    fsm_ready = 1'b0;
    if (state_q == S_IDLE) begin
      fsm_ready = 1'b1;
    end else if (state_q == S_ISSUE && GAP_CYCLES == 0) begin
      fsm_ready = 1'b1;
    end else if (state_q == S_GAP && gap_q == GAP_LAST) begin
      fsm_ready = 1'b1;
    end
  end

  assign pop     = fsm_ready && (count_q != '0);
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (rise_ok[i] && slot_q[i] == NONE) begin
        slot_d[i] = PENDING;
      end
    end
    if (push) begin
      slot_d[grant_idx] = QUEUED;
    end
    if (state_q == S_ISSUE) begin
      slot_d[slot_of(out_q)] = NONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= NONE;
      end
      pending_q <= '0;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i]    <= slot_d[i];
        pending_q[i] <= (slot_d[i] != NONE);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        rr_q     <= grant_idx + SLOT_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= req_of(grant_idx);
    end
  end

  // Issue FSM; out_q keeps the last request so floor/direction hold between strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      req_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      req_valid_q <= 1'b0;
      if (pop) begin
        out_q       <= fifo_q[rd_ptr_q];
        req_valid_q <= 1'b1;
        state_q     <= S_ISSUE;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ISSUE: begin
            gap_q   <= '0;
            state_q <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
          S_GAP: begin
            if (gap_q == GAP_LAST) begin
              state_q <= S_IDLE;
            end else begin
              gap_q <= gap_q + GAP_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign req_valid_o     = req_valid_q;
  assign req_floor_o     = out_q.floor;
  assign req_direction_o = out_q.dir;
  assign pending_down_o  = pending_q[NUM_FLOORS-1:0];
  assign pending_up_o    = pending_q[NUM_SLOTS-1:NUM_FLOORS];
  assign queue_full_o    = full_q;

endmodule

// File: doc/elevator_request_scanner.md
# elevator_request_scanner

Hall-call front end for the `elevator` controller. Synchronises and debounces the 16 raw hall buttons, records each new press once, and arbitrates pending calls round-robin into a small FIFO. Drains the FIFO as single-cycle `req_valid` pulses carrying `req_floor` and `req_direction`, spaced by a configurable gap. Outputs wire straight to the controller's `valid_in`, `req_floor` and `direction` ports.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a synchronised button level is accepted (≥1).
- `FIFO_DEPTH`, 4: request FIFO entries, power of two, ≥2.
- `GAP_CYCLES`, 2: idle cycles forced after each `req_valid` pulse (0 allowed).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset; deassertion synchronous to `clk` externally.
- `btn_up` input 8: raw up hall buttons, bit = floor, active-high, asynchronous to `clk`.
- `btn_down` input 8: raw down hall buttons, bit = floor.
- `req_valid` output 1: one-cycle request strobe.
- `req_floor` output 3: requested floor, valid while `req_valid`=1.
- `req_direction` output 1: 1 = up, 0 = down.
- `pending_up` output 8: up call latched, queued, or not yet issued (hall lamp).
- `pending_down` output 8: same for down calls.
- `queue_full` output 1: FIFO holds `FIFO_DEPTH` entries.

## Operation
- Slot index = {dir, floor}: 0–7 down, 8–15 up. `btn_up[7]` and `btn_down[0]` are ignored; their slots never set.
- Per button:
  - 2-flop synchroniser feeds a debouncer (stable bit plus counter).
  - Counter increments while synced ≠ stable and clears when they are equal.
  - On reaching `DEBOUNCE_CYCLES` the stable bit flips and the counter clears.
- A rising edge of the stable bit moves the slot from NONE to PENDING.
- A press while the slot is PENDING or QUEUED is ignored.
- Arbiter:
  - Each cycle, if the FIFO is not full, grant the first PENDING slot at or after `rr_ptr`, wrapping 15→0.
  - Push {dir, floor}; the slot becomes QUEUED; `rr_ptr` ← grant+1 mod 16.
  - At most one grant per cycle. A full FIFO stalls the arbiter. No request is ever dropped.
- Issue FSM states:
  - IDLE: FIFO not empty → pop into output registers, go to ISSUE.
  - ISSUE: `req_valid`=1 and the popped slot returns to NONE. Next state is GAP, or IDLE if `GAP_CYCLES`=0.
  - GAP: counts `GAP_CYCLES` cycles, then IDLE.
- `req_floor` and `req_direction` hold their last values outside ISSUE.
- `pending_up[f]` and `pending_down[f]` are 1 when the corresponding slot ≠ NONE.

## Timing
- Reset values:
  - `req_valid`=0, `req_floor`=0, `req_direction`=0.
  - `pending_up`=`pending_down`=0, `queue_full`=0.
  - FIFO empty, `rr_ptr`=0, all stable bits 0, FSM IDLE.
- Reset mid-operation clears everything immediately (async), including queued requests.
- A button held through reset release is seen as a new press after debounce.
- Latency, with the FIFO empty and the FSM idle: edge E0 first samples raw high.
  - Stable bit = 1 after E(DEBOUNCE_CYCLES+1).
  - Slot PENDING after E(DEBOUNCE_CYCLES+2).
  - Push at E(DEBOUNCE_CYCLES+3).
  - `req_valid` high in the cycle after E(DEBOUNCE_CYCLES+4).
- No bypass: an entry pushed into an empty FIFO is popped no earlier than the next cycle.
- Same-cycle push and pop are allowed when the FIFO is not full. When full, the push waits even if a pop occurs that cycle.
- Minimum pulse spacing is `GAP_CYCLES`+1 cycles between `req_valid` rising edges (back-to-back when 0).
- A release bounce shorter than `DEBOUNCE_CYCLES` produces no new request.

## Structure
- Shared package `elevator_pkg`:
  - `NUM_FLOORS`=8, `FLOOR_W`=3.
  - Slot state enum {NONE, PENDING, QUEUED}.
  - Issue state enum {S_IDLE, S_ISSUE, S_GAP}.
  - `DIR_UP`=1, `DIR_DOWN`=0.
- Sub-module `button_debounce`: one synchroniser plus debouncer per button, 16 instances, outputs a one-cycle rise pulse.
- FIFO, arbiter and issue FSM are in the top module.

## Test plan
- Single press, `DEBOUNCE_CYCLES`=4: `btn_up[2]` held 10 cycles → one `req_valid` pulse on the 8th edge with `req_floor`=2, `req_direction`=1; `pending_up[2]` high from edge 6 until ISSUE.
- Glitch rejection: `btn_down[5]` pulsed 3 cycles → no `req_valid`, `pending_down` stays 0.
- Duplicate suppression: `btn_up[3]` pressed twice before issue → exactly one request (3, up).
- Simultaneous presses: `btn_up[1]`, `btn_down[4]`, `btn_up[6]` rise in the same cycle → three pulses in order (4,down), (1,up), (6,up), spaced 3 cycles with `GAP_CYCLES`=2.
- Backpressure, `FIFO_DEPTH`=4: all 14 valid buttons pressed together → `queue_full` asserts, all 14 requests emerge in round-robin order starting from slot 1, none lost.
- Reset mid-queue: `reset`=0 with 3 entries queued → `req_valid`, `pending_*` and `queue_full` drop to 0 asynchronously; no pulses follow after release.
